// File: rtl/matrix_bram_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_bram_writer: header + element writer into per-id BRAM matrix slots |
// | Optional: MATRIX_WRITER_TIMEOUT_EN aborts a stalled element stream.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module matrix_bram_writer #(
  parameter int BLOCK_SIZE  = 1152,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            write_matrix_id,
  input  logic [7:0]            write_rows,
  input  logic [7:0]            write_cols,
  input  logic [7:0][7:0]       write_name,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HDR0      = 3'd1;
  localparam logic [2:0] S_HDR1      = 3'd2;
  localparam logic [2:0] S_NAME_TAIL = 3'd3;
  localparam logic [2:0] S_WR_DATA   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  localparam logic [15:0]           MAX_ELEMS = 16'(BLOCK_SIZE - 3);
  localparam logic [ADDR_WIDTH-1:0] BLK       = ADDR_WIDTH'(BLOCK_SIZE);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [7:0][7:0]       name_q;
  logic [15:0]           n_q;
  logic [15:0]           cnt;
  logic [ADDR_WIDTH-1:0] base_q;

  logic [15:0] n_req;
  logic        dims_ok;
  logic        accept;
  logic        take_elem;
  logic        last_elem;
  logic        timed_out;

  // Element count is a 16-bit product so 255x255 is caught as oversize, not wrapped.
  assign n_req     = 16'(write_rows) * 16'(write_cols);
  assign dims_ok   = (write_rows != 8'd0) && (write_cols != 8'd0) && (n_req <= MAX_ELEMS);
  assign accept    = (state == S_IDLE) && write_request;
  assign take_elem = (state == S_WR_DATA) && write_data_valid;
  assign last_elem = take_elem && (cnt == n_q - 16'd1);

`ifdef MATRIX_WRITER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != S_WR_DATA) || take_elem) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign timed_out = (state == S_WR_DATA) && !take_elem &&
                     (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (write_request) state_nxt = dims_ok ? S_HDR0 : S_ERR;
      S_HDR0:      state_nxt = S_HDR1;
      S_HDR1:      state_nxt = S_NAME_TAIL;
      S_NAME_TAIL: state_nxt = S_WR_DATA;
      S_WR_DATA: begin
        if (last_elem) begin
          state_nxt = S_DONE;
        end else if (timed_out) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE:      state_nxt = S_IDLE;
      S_ERR:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    write_ready  = 1'b0;
    writer_ready = 1'b0;
    write_done   = 1'b0;
    write_error  = 1'b0;
    case (state)
      S_IDLE:    write_ready  = 1'b1;
      S_WR_DATA: writer_ready = 1'b1;
      S_DONE:    write_done   = 1'b1;
      S_ERR:     write_error  = 1'b1;
      default:   ;
    endcase
  end

  // Request fields are captured only on acceptance; the producer may change them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0;
      cols_q <= '0;
      name_q <= '0;
      n_q    <= '0;
      base_q <= '0;
    end else if (accept) begin
      rows_q <= write_rows;
      cols_q <= write_cols;
      name_q <= write_name;
      n_q    <= n_req;
      base_q <= ADDR_WIDTH'(write_matrix_id) * BLK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (take_elem) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
    end else begin
      bram_wr_en <= 1'b0;
      case (state)
        S_HDR0: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= base_q;
          bram_wr_data <= DATA_WIDTH'({rows_q, cols_q, 16'd0});
        end
        S_HDR1: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= base_q + ADDR_WIDTH'(1);
          bram_wr_data <= DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
        end
        S_NAME_TAIL: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= base_q + BLK - ADDR_WIDTH'(1);
          bram_wr_data <= DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
        end
        S_WR_DATA: begin
          if (take_elem) begin
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= base_q + ADDR_WIDTH'(2) + ADDR_WIDTH'(cnt);
            bram_wr_data <= write_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
